// File: rtl/mips_cpu_mult_seq.sv
//------------------------------------------------------------------------------
// mips_cpu_mult_seq : iterative shift-add MULT/MULTU multiplier, 1 bit/cycle.
// Optional macro: MULT_SEQ_EARLY_OUT_EN (leave RUN once the multiplier is empty)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_cpu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] out_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               run_last;

  // Magnitudes are unsigned, so the most negative value maps onto 2^(WIDTH-1).
  assign mag_a = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    out_d    = out_q;
    done_d   = 1'b0;
    run_last = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          neg_d    = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // mcand_q holds mag_a << count, kept pre-shifted to avoid a barrel shifter.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
`ifdef MULT_SEQ_EARLY_OUT_EN
        run_last = (count_d == CW'(WIDTH)) || (mplier_d == '0);
`else
        run_last = (count_d == CW'(WIDTH));
`endif
        if (run_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        out_d   = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign out_o  = out_q;

endmodule

`default_nettype wire

// File: doc/mips_cpu_mult_seq.md
# mips_cpu_mult_seq

Parametrised, iterative shift-add multiplier for the MIPS32 execute stage, serving MULT/MULTU. It replaces the single-shot signed/unsigned multiplier wrapper with a WIDTH-generic, one-bit-per-cycle datapath. A start/busy/done handshake lets the control FSM stall only while HI/LO is pending. Sign handling uses magnitude conversion on entry and a product fix-up on exit, so one unsigned core serves both opcodes.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH; legal values ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- sign  in  1  1 = signed (MULT), 0 = unsigned (MULTU); captured with start.
- a  in  WIDTH  multiplicand; captured with start.
- b  in  WIDTH  multiplier; captured with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; out valid from this cycle on.
- out  out  2*WIDTH  product (HI = upper WIDTH, LO = lower WIDTH); held until the next done.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - if start=1, capture sign_neg = sign & (a[MSB] ^ b[MSB]).
  - capture mag_a = (sign & a[MSB]) ? -a : a, and mag_b likewise, both as WIDTH-bit unsigned; -(2^(WIDTH-1)) maps to 2^(WIDTH-1).
  - clear acc (2*WIDTH), load count = 0, go to RUN.
- RUN, each cycle:
  - if mag_b[0], acc += mag_a << count.
  - mag_b >>= 1; count++.
  - after iteration WIDTH-1 (count reaches WIDTH), go to FIX.
- FIX:
  - out <= sign_neg ? -acc (mod 2^(2*WIDTH)) : acc.
  - done <= 1; go to IDLE.
- done is high for exactly one cycle; busy = (state != IDLE).
- start with busy=1 is ignored: no capture and no effect on the operation in flight.
- start in the same cycle as done=1 is accepted, because state is already IDLE.
- Inputs a, b, and sign may change freely after capture.
- All arithmetic is modulo 2^(2*WIDTH); no overflow flag.

## Timing
- Reset values: busy=0, done=0, out=0, state=IDLE.
- Accept edge E0 (IDLE, start=1).
- RUN occupies edges E1..E_WIDTH; FIX is at edge E_(WIDTH+1).
- Cycle after E_(WIDTH+1): done=1, busy=0, out valid.
- Latency start→done = WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back throughput: one result per WIDTH+1 cycles.
- reset=1 at any edge, including mid-RUN or coincident with start:
  - next cycle state=IDLE, busy=0, done=0, out=0.
  - the in-flight result is discarded and the start is not accepted.

## Configuration
- MULT_SEQ_EARLY_OUT_EN:
  - Defined: RUN exits to FIX at the first edge where the shifted mag_b becomes 0.
    - RUN length = max(1, bit-length of |b|).
    - Latency = RUN length + 1; the minimum is 2, reached for b=0 or |b|=1.
    - Result is identical to the fixed-latency build.
  - Undefined: RUN is always WIDTH cycles and latency is always WIDTH+1.
  - Control must rely only on done, never on a fixed count.

## Test plan
- Unsigned, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, sign=0 → out=0xFFFFFFFE_00000001.
  - Macro off: done exactly 33 cycles after start; busy high for 33 cycles.
- Signed: a=0xFFFFFFFD (-3), b=5 → out=0xFFFFFFFF_FFFFFFF1; a=0xFFFFFFFF, b=0xFFFFFFFF → out=0x00000000_00000001.
- Signed corners:
  - a=b=0x80000000 → out=0x40000000_00000000.
  - a=0, b=0x80000000 → out=0 (no -0 artefact).
- Handshake:
  - start=1 held through a whole operation with changing a/b → result matches the operands at the accept edge.
  - Second start in the done cycle with a=7, b=6, sign=0 → accepted, next out=42.
- Reset mid-RUN at cycle 10 → busy=0, done=0, out=0 next cycle; no done pulse follows.
- MULT_SEQ_EARLY_OUT_EN defined:
  - a=9, b=3, sign=0 → out=27, done 3 cycles after start.
  - b=0 → out=0, done 2 cycles after start.
  - b=0x80000000 unsigned → full 33-cycle latency.
